// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the MEMORY stage.
// Word RAM with byte-lane stores, sized extended loads, LED toggle register.
//
// Ports:
//   clk, resetn            clock, async active-low reset
//   req_valid/req_ready    request handshake (ready only in IDLE)
//   req_we, req_addr       store/load select, byte address
//   req_size, req_unsigned 00 byte / 01 half / 10 word; zero-extend select
//   req_wdata              right-aligned store data
//   rsp_valid              one-cycle response pulse
//   rsp_rdata, rsp_err     extended load data / error flag
//   toggle_value           memory-mapped toggle register contents
module dmem_responder #(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] TOGGLE_ADDR = 32'd52
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] toggle_value
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [29:0] DEPTH_W = 30'(DEPTH_WORDS);
    localparam logic [29:0] TOG_W   = TOGGLE_ADDR[31:2];

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t state_q, state_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic        we_q;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [31:0] tog_q;

    logic [29:0] widx;
    logic [1:0]  lane;
    logic        tog_hit;
    logic        in_range;
    logic        is_byte;
    logic        is_half;
    logic        is_word;
    logic        sx;
    logic [31:0] rd_word;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [3:0]  be;
    logic [31:0] mask;
    logic [31:0] wdat;
    logic [31:0] merged;
    logic [31:0] ld;
    logic        bad;
    logic        commit;

    assign widx     = addr_q[31:2];
    assign lane     = addr_q[1:0];
    assign tog_hit  = (widx == TOG_W);
    assign in_range = (widx < DEPTH_W);
    assign is_byte  = (size_q == 2'b00);
    assign is_half  = (size_q == 2'b01);
    assign is_word  = (size_q == 2'b10);
    assign sx       = ~uns_q;

    // Toggle register shadows the RAM word at its address.
    assign rd_word  = tog_hit ? tog_q : mem[addr_q[AW+1:2]];
    assign byte_sel = rd_word[{lane, 3'b000} +: 8];
    assign half_sel = rd_word[{lane[1], 4'b0000} +: 16];

    always_comb begin
        be   = 4'b0000;
        wdat = wdata_q;
        ld   = rd_word;
        bad  = 1'b0;
        unique case (1'b1)
            is_byte: begin
                be   = 4'b0001 << lane;
                wdat = {4{wdata_q[7:0]}};
                ld   = {{24{sx & byte_sel[7]}}, byte_sel};
            end
            is_half: begin
                be   = lane[1] ? 4'b1100 : 4'b0011;
                wdat = {2{wdata_q[15:0]}};
                ld   = {{16{sx & half_sel[15]}}, half_sel};
                bad  = lane[0];
            end
            is_word: begin
                be   = 4'b1111;
                bad  = (lane != 2'b00);
            end
            default: begin
                bad  = 1'b1;
            end
        endcase
        if (!in_range && !tog_hit) begin
            bad = 1'b1;
        end
    end

    assign mask   = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    assign merged = (rd_word & ~mask) | (wdat & mask);
    assign commit = (state_q == ACCESS) && !bad;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                state_d = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            tog_q   <= '0;
        end else begin
            if (state_q == IDLE && req_valid) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                size_q  <= req_size;
                uns_q   <= req_unsigned;
                wdata_q <= req_wdata;
            end
            if (state_q == ACCESS) begin
                err_q   <= bad;
                rdata_q <= (bad || we_q) ? 32'h0 : ld;
                if (commit && we_q && tog_hit) begin
                    tog_q <= merged;
                end
            end else if (state_q == RESP) begin
                err_q   <= 1'b0;
                rdata_q <= '0;
            end
        end
    end

    // RAM has no reset; a write only happens from ACCESS, which reset leaves.
    always_ff @(posedge clk) begin
        if (commit && we_q && !tog_hit) begin
            mem[addr_q[AW+1:2]] <= merged;
        end
    end

    assign rsp_rdata    = rdata_q;
    assign rsp_err      = err_q;
    assign toggle_value = tog_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: bench for dmem_responder.
// Directed vector table, handshake corner sequences, randomized model check.
module tb_dmem_responder;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] toggle_value;

    dmem_responder #(
        .DEPTH_WORDS(DEPTH),
        .TOGGLE_ADDR(32'd52)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we(req_we),
        .req_addr(req_addr),
        .req_size(req_size),
        .req_unsigned(req_unsigned),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .toggle_value(toggle_value)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: byte-addressed memory plus the toggle register.
    byte unsigned m_mem [DEPTH*4];
    logic [31:0]  m_tog = '0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tbl [25];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic void model(input logic we, input logic [31:0] addr,
                                  input logic [1:0] size, input logic uns,
                                  input logic [31:0] wdata,
                                  output logic [31:0] rd, output logic err);
        int n;
        logic [31:0] v;
        logic [31:0] a;
        n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        err = (size == 2'd3) || ((addr % n) != 0) ||
              ((addr / 4 != 32'd13) && (addr >= DEPTH*4));
        rd = '0;
        if (err) return;
        v = '0;
        for (int i = 0; i < n; i++) begin
            a = addr + i;
            if (a / 4 == 32'd13) begin
                if (we) m_tog[8*(a%4) +: 8] = wdata[8*i +: 8];
                v[8*i +: 8] = m_tog[8*(a%4) +: 8];
            end else begin
                if (we) m_mem[a] = wdata[8*i +: 8];
                v[8*i +: 8] = m_mem[a];
            end
        end
        if (we) rd = '0;
        else if (n < 4 && !uns && v[8*n-1]) rd = v | (32'hFFFF_FFFF << (8*n));
        else rd = v;
    endfunction

    task automatic do_req(input logic we, input logic [31:0] addr,
                          input logic [1:0] size, input logic uns,
                          input logic [31:0] wdata,
                          output logic [31:0] rd, output logic err);
        int waits = 0;
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_size     = size;
        req_unsigned = uns;
        req_wdata    = wdata;
        while (!req_ready && waits < 10) begin
            @(negedge clk);
            waits++;
        end
        chk("ready_before_accept", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("access_phase", {30'b0, req_ready, rsp_valid}, 32'b00);
        @(posedge clk);
        #1;
        chk("rsp_valid_pulse", {30'b0, req_ready, rsp_valid}, 32'b01);
        rd  = rsp_rdata;
        err = rsp_err;
        @(posedge clk);
        #1;
        chk("rsp_drop", {30'b0, req_ready, rsp_valid}, 32'b10);
    endtask

    task automatic run_check(input string name, input logic we,
                             input logic [31:0] addr, input logic [1:0] size,
                             input logic uns, input logic [31:0] wdata);
        logic [31:0] erd, ard;
        logic        eerr, aerr;
        model(we, addr, size, uns, wdata, erd, eerr);
        do_req(we, addr, size, uns, wdata, ard, aerr);
        chk({name, "_rdata"}, ard, erd);
        chk({name, "_err"}, 32'(aerr), 32'(eerr));
        chk({name, "_toggle"}, toggle_value, m_tog);
    endtask

    initial begin
        logic [31:0] rd;
        logic        err;
        logic [31:0] mrd;
        logic        merr;
        logic [31:0] addr;
        logic [1:0]  sz;
        int          acc [$];

        tbl[0]  = '{1'b1, 32'h010, 2'd2, 1'b0, 32'h1234_5678, 32'h0000_0000, 1'b0};
        tbl[1]  = '{1'b0, 32'h010, 2'd2, 1'b0, 32'h0,         32'h1234_5678, 1'b0};
        tbl[2]  = '{1'b1, 32'h100, 2'd2, 1'b0, 32'h0,         32'h0000_0000, 1'b0};
        tbl[3]  = '{1'b1, 32'h101, 2'd0, 1'b0, 32'h1234_56AB, 32'h0000_0000, 1'b0};
        tbl[4]  = '{1'b0, 32'h100, 2'd2, 1'b0, 32'h0,         32'h0000_AB00, 1'b0};
        tbl[5]  = '{1'b0, 32'h101, 2'd0, 1'b0, 32'h0,         32'hFFFF_FFAB, 1'b0};
        tbl[6]  = '{1'b0, 32'h101, 2'd0, 1'b1, 32'h0,         32'h0000_00AB, 1'b0};
        tbl[7]  = '{1'b1, 32'h102, 2'd1, 1'b0, 32'hDEAD_8001, 32'h0000_0000, 1'b0};
        tbl[8]  = '{1'b0, 32'h102, 2'd1, 1'b0, 32'h0,         32'hFFFF_8001, 1'b0};
        tbl[9]  = '{1'b0, 32'h103, 2'd1, 1'b0, 32'h0,         32'h0000_0000, 1'b1};
        tbl[10] = '{1'b0, 32'h100, 2'd2, 1'b0, 32'h0,         32'h8001_AB00, 1'b0};
        tbl[11] = '{1'b0, 32'h102, 2'd1, 1'b1, 32'h0,         32'h0000_8001, 1'b0};
        tbl[12] = '{1'b1, 32'd52,  2'd2, 1'b0, 32'h0000_0001, 32'h0000_0000, 1'b0};
        tbl[13] = '{1'b0, 32'd52,  2'd2, 1'b0, 32'h0,         32'h0000_0001, 1'b0};
        tbl[14] = '{1'b1, 32'd53,  2'd0, 1'b0, 32'h0000_00FF, 32'h0000_0000, 1'b0};
        tbl[15] = '{1'b0, 32'd53,  2'd0, 1'b0, 32'h0,         32'hFFFF_FFFF, 1'b0};
        tbl[16] = '{1'b0, 32'd52,  2'd1, 1'b1, 32'h0,         32'h0000_FF01, 1'b0};
        tbl[17] = '{1'b0, 32'd1024, 2'd2, 1'b0, 32'h0,        32'h0000_0000, 1'b1};
        tbl[18] = '{1'b0, 32'h102, 2'd2, 1'b0, 32'h0,         32'h0000_0000, 1'b1};
        tbl[19] = '{1'b0, 32'h100, 2'd3, 1'b0, 32'h0,         32'h0000_0000, 1'b1};
        tbl[20] = '{1'b1, 32'd1024, 2'd0, 1'b0, 32'h55,       32'h0000_0000, 1'b1};
        tbl[21] = '{1'b0, 32'h8000_0034, 2'd2, 1'b0, 32'h0,   32'h0000_0000, 1'b1};
        tbl[22] = '{1'b0, 32'h103, 2'd0, 1'b0, 32'h0,         32'hFFFF_FF80, 1'b0};
        tbl[23] = '{1'b1, 32'h3FC, 2'd2, 1'b0, 32'hCAFE_F00D, 32'h0000_0000, 1'b0};
        tbl[24] = '{1'b0, 32'h3FC, 2'd2, 1'b0, 32'h0,         32'hCAFE_F00D, 1'b0};

        // Reset values while held in reset.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready",  32'(req_ready), 32'd1);
        chk("rst_valid",  32'(rsp_valid), 32'd0);
        chk("rst_rdata",  rsp_rdata, 32'd0);
        chk("rst_err",    32'(rsp_err), 32'd0);
        chk("rst_toggle", toggle_value, 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Give every RAM word a known value (word 13 is shadowed).
        for (int w = 0; w < DEPTH; w++) begin
            if (w != 13) begin
                addr = 32'(w * 4);
                model(1'b1, addr, 2'd2, 1'b0, $urandom, mrd, merr);
                do_req(1'b1, addr, 2'd2, 1'b0,
                       {m_mem[addr+3], m_mem[addr+2], m_mem[addr+1], m_mem[addr]},
                       rd, err);
                chk("init_err", 32'(err), 32'd0);
            end
        end
        chk("init_toggle", toggle_value, 32'd0);

        // Directed vectors.
        for (int i = 0; i < 25; i++) begin
            model(tbl[i].we, tbl[i].addr, tbl[i].size, tbl[i].uns,
                  tbl[i].wdata, mrd, merr);
            do_req(tbl[i].we, tbl[i].addr, tbl[i].size, tbl[i].uns,
                   tbl[i].wdata, rd, err);
            chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
            chk($sformatf("vec%0d_err", i), 32'(err), 32'(tbl[i].exp_err));
            chk($sformatf("vec%0d_toggle", i), toggle_value, m_tog);
        end

        // RAM around the toggle word is untouched by toggle stores.
        run_check("near_tog_lo", 1'b0, 32'd48, 2'd2, 1'b0, 32'h0);
        run_check("near_tog_hi", 1'b0, 32'd56, 2'd2, 1'b0, 32'h0);

        // req_valid held high: accepts every third edge.
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = 1'b0;
        req_addr     = 32'h10;
        req_size     = 2'd2;
        req_unsigned = 1'b0;
        for (int c = 0; c < 12 && acc.size() < 3; c++) begin
            if (req_ready) acc.push_back(c);
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("b2b_count", 32'(acc.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("b2b_accept%0d", i),
                32'(acc.size() > i ? acc[i] : -1), 32'(3 * i));
        end
        repeat (3) @(negedge clk);
        chk("b2b_idle", 32'(req_ready), 32'd1);

        // Reset during ACCESS of a store drops it and the response.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h20;
        req_size  = 2'd2;
        req_wdata = 32'hA5A5_A5A5;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        resetn    = 1'b0;
        #1;
        m_tog = '0;
        chk("mid_rst_ready",  32'(req_ready), 32'd1);
        chk("mid_rst_toggle", toggle_value, 32'd0);
        chk("mid_rst_valid",  32'(rsp_valid), 32'd0);
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("mid_rst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        @(negedge clk);
        resetn = 1'b1;
        run_check("after_rst_load", 1'b0, 32'h20, 2'd2, 1'b0, 32'h0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 300; i++) begin
            int r;
            r  = $urandom_range(0, 9);
            sz = 2'($urandom_range(0, 3));
            if (r < 6)       addr = 32'($urandom_range(0, 1023));
            else if (r < 8)  addr = 32'd52 + 32'($urandom_range(0, 3));
            else if (r == 8) addr = 32'd1024 + 32'($urandom_range(0, 63));
            else             addr = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) addr[0] = 1'b0;
                if (sz == 2'd2) addr[1:0] = 2'b00;
            end
            run_check("rand", 1'($urandom_range(0, 1)), addr, sz,
                      1'($urandom_range(0, 1)), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
